// File: rtl/pq_cmd_master.sv
// pq_cmd_master: turns a valid/ready command stream (ENQ/DEQ/REPLACE/NOP)
// into single-cycle enq/deq strobes toward a priority-queue device. It
// returns dequeued pairs on a valid/ready response stream and keeps
// saturating drop/error counters. Only one command is in flight at a time.
module pq_cmd_master #(
  parameter int KW = 8,
  parameter int VW = 8,
  parameter int CW = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [KW+VW-1:0] cmd_kv,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [KW+VW-1:0] rsp_kv,
  output logic             rsp_err,
  output logic             pq_enq,
  output logic             pq_deq,
  output logic [KW+VW-1:0] pq_kvi,
  input  logic [KW+VW-1:0] pq_kvo,
  input  logic             pq_busy,
  input  logic             pq_full,
  input  logic             pq_empty,
  output logic [CW-1:0]    enq_drop_cnt,
  output logic [CW-1:0]    deq_err_cnt
);

  localparam int KVW = KW + VW;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_ENQ = 2'b01;
  localparam logic [1:0] OP_DEQ = 2'b10;
  localparam logic [1:0] OP_REP = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RESP  = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [KVW-1:0]  kv_q, kv_d;
  logic [KVW-1:0]  rsp_kv_q, rsp_kv_d;
  logic            rsp_err_q, rsp_err_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   derr_q, derr_d;
  logic            cmd_ready_s;
  logic            pq_enq_s;
  logic            pq_deq_s;

  // Saturating increment: an all-ones counter holds its value.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    if (&c) begin
      return c;
    end else begin
      return c + {{(CW-1){1'b0}}, 1'b1};
    end
  endfunction

  // State register plus latched command, response and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_NOP;
      kv_q      <= {KVW{1'b0}};
      rsp_kv_q  <= {KVW{1'b0}};
      rsp_err_q <= 1'b0;
      drop_q    <= {CW{1'b0}};
      derr_q    <= {CW{1'b0}};
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      kv_q      <= kv_d;
      rsp_kv_q  <= rsp_kv_d;
      rsp_err_q <= rsp_err_d;
      drop_q    <= drop_d;
      derr_q    <= derr_d;
    end
  end

  // Next-state and strobe decode; strobes only ever fire in ISSUE with the device idle.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    kv_d        = kv_q;
    rsp_kv_d    = rsp_kv_q;
    rsp_err_d   = rsp_err_q;
    drop_d      = drop_q;
    derr_d      = derr_q;
    cmd_ready_s = 1'b0;
    pq_enq_s    = 1'b0;
    pq_deq_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready_s = 1'b1;
        if (cmd_valid && (cmd_op != OP_NOP)) begin
          op_d    = cmd_op;
          kv_d    = cmd_kv;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (!pq_busy) begin
          case (op_q)
            OP_ENQ: begin
              if (!pq_full) begin
                pq_enq_s = 1'b1;
              end else begin
                drop_d = sat_inc(drop_q);
              end
              state_d = ST_IDLE;
            end
            OP_DEQ, OP_REP: begin
              if (!pq_empty) begin
                // REPLACE keeps occupancy constant, so it may go even when full.
                pq_deq_s  = 1'b1;
                pq_enq_s  = (op_q == OP_REP);
                rsp_kv_d  = pq_kvo;
                rsp_err_d = 1'b0;
              end else begin
                rsp_kv_d  = {KVW{1'b0}};
                rsp_err_d = 1'b1;
                derr_d    = sat_inc(derr_q);
              end
              state_d = ST_RESP;
            end
            default: begin
              state_d = ST_IDLE;
            end
          endcase
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign cmd_ready    = cmd_ready_s;
  assign rsp_valid    = (state_q == ST_RESP);
  assign rsp_kv       = rsp_kv_q;
  assign rsp_err      = rsp_err_q;
  assign pq_enq       = pq_enq_s;
  assign pq_deq       = pq_deq_s;
  assign pq_kvi       = kv_q;
  assign enq_drop_cnt = drop_q;
  assign deq_err_cnt  = derr_q;

endmodule

// File: tb/tb_pq_cmd_master.sv
// Directed bench for pq_cmd_master with a small sorted-array PQ device model.
module tb_pq_cmd_master;

  localparam int KW = 8;
  localparam int VW = 8;
  localparam int CW = 4;
  localparam int DEPTH = 4;

  localparam logic [1:0] NOP = 2'b00;
  localparam logic [1:0] ENQ = 2'b01;
  localparam logic [1:0] DEQ = 2'b10;
  localparam logic [1:0] REP = 2'b11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [15:0]   cmd_kv;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [15:0]   rsp_kv;
  logic          rsp_err;
  logic          pq_enq;
  logic          pq_deq;
  logic [15:0]   pq_kvi;
  logic [15:0]   pq_kvo;
  logic          pq_busy;
  logic          pq_full;
  logic          pq_empty;
  logic [CW-1:0] enq_drop_cnt;
  logic [CW-1:0] deq_err_cnt;

  int checks = 0;
  int errors = 0;
  int enq_pulses = 0;
  int deq_pulses = 0;
  int busy_viol = 0;
  int full_viol = 0;

  always #5 clk = ~clk;

  pq_cmd_master #(.KW(KW), .VW(VW), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_kv(cmd_kv),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_kv(rsp_kv), .rsp_err(rsp_err),
    .pq_enq(pq_enq), .pq_deq(pq_deq), .pq_kvi(pq_kvi), .pq_kvo(pq_kvo),
    .pq_busy(pq_busy), .pq_full(pq_full), .pq_empty(pq_empty),
    .enq_drop_cnt(enq_drop_cnt), .deq_err_cnt(deq_err_cnt)
  );

  // Device model: ascending sorted array, smaller key at index 0.
  logic [15:0] mem_q [DEPTH];
  logic [15:0] mem_d [DEPTH];
  int cnt_q, cnt_d;

  assign pq_kvo   = (cnt_q > 0) ? mem_q[0] : 16'h0000;
  assign pq_full  = (cnt_q == DEPTH);
  assign pq_empty = (cnt_q == 0);

  // Model next state from the strobes (deq removes head, then enq inserts).
  always_comb begin
    int pos;
    mem_d = mem_q;
    cnt_d = cnt_q;
    pos = 0;
    if (pq_deq && cnt_d > 0) begin
      for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_d[i+1];
      mem_d[DEPTH-1] = 16'h0000;
      cnt_d = cnt_d - 1;
    end
    if (pq_enq && cnt_d < DEPTH) begin
      pos = cnt_d;
      for (int i = DEPTH - 1; i >= 0; i--)
        if (i < cnt_d && mem_d[i][15:8] > pq_kvi[15:8]) pos = i;
      for (int i = DEPTH - 1; i > 0; i--)
        if (i > pos) mem_d[i] = mem_d[i-1];
      mem_d[pos] = pq_kvi;
      cnt_d = cnt_d + 1;
    end
  end

  // Model register.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 16'h0000;
    end else begin
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

  // Strobe counters and protocol monitors.
  always @(posedge clk) begin
    if (rst_n) begin
      enq_pulses <= enq_pulses + (pq_enq ? 1 : 0);
      deq_pulses <= deq_pulses + (pq_deq ? 1 : 0);
      if (pq_busy && (pq_enq || pq_deq)) busy_viol <= busy_viol + 1;
      if (pq_enq && !pq_deq && pq_full) full_viol <= full_viol + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issue one command; collect the response if one is expected.
  task automatic run_cmd(input logic [1:0] op, input logic [15:0] kv, input bit has_rsp,
                         output logic [15:0] got_kv, output logic got_err,
                         output int d_enq, output int d_deq);
    int e0, d0;
    got_kv = 16'h0000;
    got_err = 1'b0;
    @(negedge clk);
    e0 = enq_pulses;
    d0 = deq_pulses;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_kv = kv;
    for (int t = 0; t < 50 && !cmd_ready; t++) @(negedge clk);
    chk("cmd_accept", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = NOP;
    if (has_rsp) begin
      rsp_ready = 1'b1;
      @(negedge clk);
      for (int t = 0; t < 50 && !rsp_valid; t++) @(negedge clk);
      chk("rsp_arrive", {31'd0, rsp_valid}, 32'd1);
      got_kv = rsp_kv;
      got_err = rsp_err;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
    end else begin
      @(negedge clk);
      if (op == ENQ) chk("enq_issue_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
      chk("back_to_idle", {31'd0, cmd_ready}, 32'd1);
    end
    d_enq = enq_pulses - e0;
    d_deq = deq_pulses - d0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [15:0] kv;
    bit          has_rsp;
    logic [15:0] exp_kv;
    logic        exp_err;
    int          exp_enq;
    int          exp_deq;
    int          exp_drop;
    int          exp_derr;
  } vec_t;

  vec_t vecs [17];

  initial begin
    logic [15:0] gkv;
    logic gerr;
    int de, dd;

    vecs[0]  = '{ENQ, 16'h30A0, 1'b0, 16'h0000, 1'b0, 1, 0, 0, 0};
    vecs[1]  = '{ENQ, 16'h10B0, 1'b0, 16'h0000, 1'b0, 1, 0, 0, 0};
    vecs[2]  = '{ENQ, 16'h20C0, 1'b0, 16'h0000, 1'b0, 1, 0, 0, 0};
    vecs[3]  = '{DEQ, 16'h0000, 1'b1, 16'h10B0, 1'b0, 0, 1, 0, 0};
    vecs[4]  = '{DEQ, 16'h0000, 1'b1, 16'h20C0, 1'b0, 0, 1, 0, 0};
    vecs[5]  = '{DEQ, 16'h0000, 1'b1, 16'h30A0, 1'b0, 0, 1, 0, 0};
    vecs[6]  = '{DEQ, 16'h0000, 1'b1, 16'h0000, 1'b1, 0, 0, 0, 1};
    vecs[7]  = '{REP, 16'h4444, 1'b1, 16'h0000, 1'b1, 0, 0, 0, 2};
    vecs[8]  = '{NOP, 16'h9999, 1'b0, 16'h0000, 1'b0, 0, 0, 0, 2};
    vecs[9]  = '{ENQ, 16'h4001, 1'b0, 16'h0000, 1'b0, 1, 0, 0, 2};
    vecs[10] = '{ENQ, 16'h5002, 1'b0, 16'h0000, 1'b0, 1, 0, 0, 2};
    vecs[11] = '{ENQ, 16'h6003, 1'b0, 16'h0000, 1'b0, 1, 0, 0, 2};
    vecs[12] = '{ENQ, 16'h7004, 1'b0, 16'h0000, 1'b0, 1, 0, 0, 2};
    vecs[13] = '{ENQ, 16'h0506, 1'b0, 16'h0000, 1'b0, 0, 0, 1, 2};
    vecs[14] = '{REP, 16'h0507, 1'b1, 16'h4001, 1'b0, 1, 1, 1, 2};
    vecs[15] = '{DEQ, 16'h0000, 1'b1, 16'h0507, 1'b0, 0, 1, 1, 2};
    vecs[16] = '{DEQ, 16'h0000, 1'b1, 16'h5002, 1'b0, 0, 1, 1, 2};

    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = NOP;
    cmd_kv = 16'h0000;
    rsp_ready = 1'b0;
    pq_busy = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_kv", {16'd0, rsp_kv}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_strobes", {30'd0, pq_enq, pq_deq}, 32'd0);
    chk("rst_pq_kvi", {16'd0, pq_kvi}, 32'd0);
    chk("rst_counters", {24'd0, enq_drop_cnt, deq_err_cnt}, 32'd0);

    // Table-driven main function.
    for (int v = 0; v < 17; v++) begin
      run_cmd(vecs[v].op, vecs[v].kv, vecs[v].has_rsp, gkv, gerr, de, dd);
      if (vecs[v].has_rsp) begin
        chk($sformatf("v%0d_rsp_kv", v), {16'd0, gkv}, {16'd0, vecs[v].exp_kv});
        chk($sformatf("v%0d_rsp_err", v), {31'd0, gerr}, {31'd0, vecs[v].exp_err});
      end
      chk($sformatf("v%0d_enq_pulses", v), de, vecs[v].exp_enq);
      chk($sformatf("v%0d_deq_pulses", v), dd, vecs[v].exp_deq);
      chk($sformatf("v%0d_drop_cnt", v), {28'd0, enq_drop_cnt}, vecs[v].exp_drop);
      chk($sformatf("v%0d_derr_cnt", v), {28'd0, deq_err_cnt}, vecs[v].exp_derr);
    end

    // Busy stall: device holds 6003, 7004.
    @(negedge clk);
    pq_busy = 1'b1;
    cmd_valid = 1'b1;
    cmd_op = DEQ;
    chk("stall_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = NOP;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("stall_no_strobe_%0d", i), {30'd0, pq_enq, pq_deq}, 32'd0);
    end
    pq_busy = 1'b0;
    #1;
    chk("stall_deq_strobe", {30'd0, pq_enq, pq_deq}, 32'd1);
    chk("stall_rsp_not_yet", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("stall_rsp_kv", {16'd0, rsp_kv}, 32'h6003);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;

    // Response backpressure for 5 cycles, handshake in the 6th.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = DEQ;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = NOP;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_valid_%0d", i), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("bp_kv_%0d", i), {16'd0, rsp_kv}, 32'h7004);
      chk($sformatf("bp_cmd_ready_%0d", i), {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    chk("bp_kv_final", {16'd0, rsp_kv}, 32'h7004);
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    chk("bp_idle_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_idle_ready", {31'd0, cmd_ready}, 32'd1);

    // Reset while a response is pending.
    run_cmd(ENQ, 16'h2233, 1'b0, gkv, gerr, de, dd);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = DEQ;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = NOP;
    @(negedge clk);
    @(negedge clk);
    chk("rr_in_resp", {31'd0, rsp_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rr_valid_drop", {31'd0, rsp_valid}, 32'd0);
    chk("rr_rsp_kv", {16'd0, rsp_kv}, 32'd0);
    chk("rr_strobes", {30'd0, pq_enq, pq_deq}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rr_counters", {24'd0, enq_drop_cnt, deq_err_cnt}, 32'd0);

    // Counter saturation on an empty device (CW=4 saturates at 15).
    for (int i = 0; i < 16; i++) begin
      run_cmd(DEQ, 16'h0000, 1'b1, gkv, gerr, de, dd);
      chk($sformatf("sat_err_%0d", i), {15'd0, gerr, gkv}, 32'h0001_0000);
      if (i == 14) chk("sat_at_15", {28'd0, deq_err_cnt}, 32'd15);
    end
    chk("sat_held", {28'd0, deq_err_cnt}, 32'd15);

    chk("busy_strobe_viol", busy_viol, 32'd0);
    chk("full_enq_viol", full_viol, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
